// File: rtl/convolution_if.sv
// Pixel stream bundle between an image source and the 3x3 blur stage.
// The source drives inputPixel; the filter returns outputPixel with its status code.
interface convolution_if #(
    parameter int unsigned WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] inputPixel;
    logic [WORD_SIZE-1:0] outputPixel;
    logic [1:0]           valid;

    modport master (
        output inputPixel,
        input  outputPixel,
        input  valid
    );

    modport slave (
        input  inputPixel,
        output outputPixel,
        output valid
    );
endinterface

// File: rtl/convolution.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) over a raster pixel stream.
// Two row-deep line buffers feed a 3x3 window; result and status are registered one clock later.
module convolution #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ROW_SIZE  = 540
) (
    input logic          clk,
    input logic          rst,
    convolution_if.slave bus
);
    localparam int unsigned ColW = (ROW_SIZE > 2) ? $clog2(ROW_SIZE) : 2;
    localparam int unsigned SumW = WORD_SIZE + 4;
    localparam logic [ColW-1:0] ColLast = ColW'(ROW_SIZE - 1);

    typedef logic [WORD_SIZE-1:0] pixel_t;

    typedef enum logic [1:0] {
        StFill  = 2'b00,
        StValid = 2'b01,
        StWrap  = 2'b10
    } status_e;

    logic [ColW-1:0] col_q, col_d;
    logic [1:0]      row_q, row_d;

    pixel_t lb0 [ROW_SIZE];
    pixel_t lb1 [ROW_SIZE];
    pixel_t lb0_rd;
    pixel_t lb1_rd;

    pixel_t  win_q [3][3];
    status_e win_status_q, win_status_d;

    logic [SumW-1:0] sum;
    pixel_t          out_d;
    pixel_t          out_q;
    status_e         valid_q;

    // Buffers are indexed by column: the slot still holds last row's pixel until rewritten.
    assign lb0_rd = lb0[col_q];
    assign lb1_rd = lb1[col_q];

    always_comb begin
        col_d = col_q + ColW'(1);
        row_d = row_q;
        if (col_q == ColLast) begin
            col_d = '0;
            if (row_q != 2'd2) begin
                row_d = row_q + 2'd1;
            end
        end
    end

    // Status of the window that will hold the pixel being sampled this edge.
    always_comb begin
        win_status_d = StValid;
        if (row_q < 2'd2) begin
            win_status_d = StFill;
        end else if (col_q < ColW'(2)) begin
            win_status_d = StWrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_status_q <= StFill;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_status_q <= win_status_d;
        end
    end

    // Line-buffer storage is left unreset; status gating hides stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            lb0[col_q] <= bus.inputPixel;
            lb1[col_q] <= lb0_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= bus.inputPixel;
        end
    end

    // Kernel weights are powers of two: centre x4, edges x2, corners x1.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum = sum + (SumW'(win_q[i][j]) << ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
            end
        end
    end

    always_comb begin
        out_d = '0;
        if (win_status_q == StValid) begin
            out_d = sum[SumW-1:4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= '0;
            valid_q <= StFill;
        end else begin
            out_q   <= out_d;
            valid_q <= win_status_q;
        end
    end

    assign bus.outputPixel = out_q;
    assign bus.valid       = valid_q;

endmodule

// File: tb/tb_convolution.sv
// Self-checking bench for the 3x3 blur: full-width (540) and narrow (4) instances
// checked against an image-level reference model and hand-derived constants.
module tb_convolution;
    localparam int ROW  = 540;
    localparam int SROW = 4;

    logic clk;
    logic rst;
    logic rst_s;
    int   checks;
    int   failures;

    logic [7:0] img [8][ROW];

    convolution_if #(.WORD_SIZE(8)) bus ();
    convolution_if #(.WORD_SIZE(8)) bus_s ();

    convolution #(.WORD_SIZE(8), .ROW_SIZE(ROW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    convolution #(.WORD_SIZE(8), .ROW_SIZE(SROW)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Status the spec assigns to the window ending at pixel (r,c) of the current frame.
    function automatic logic [1:0] model_code(input int r, input int c);
        if (r < 2) return 2'b00;
        if (c < 2) return 2'b10;
        return 2'b01;
    endfunction

    // Blur of the window whose bottom-right pixel is (r,c); weight = (2-|dy|)*(2-|dx|).
    function automatic logic [7:0] model_px(input int r, input int c);
        int acc;
        acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                acc += (2 - iabs(dy)) * (2 - iabs(dx)) * int'(img[r - 1 + dy][c - 1 + dx]);
            end
        end
        return 8'(acc / 16);
    endfunction

    task automatic drive(input logic [7:0] px);
        bus.inputPixel = px;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.inputPixel = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.inputPixel = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.outputPixel !== 8'h00) begin
            failures++;
            $display("FAIL reset_pixel got=%h want=00", bus.outputPixel);
        end
        checks++;
        if (bus.valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid got=%b want=00", bus.valid);
        end
        rst = 1'b1;
        for (int n = 0; n < 2 * ROW; n++) begin
            drive(8'hFF);
            checks++;
            if (bus.valid !== 2'b00) begin
                failures++;
                $display("FAIL fill_valid n=%0d got=%b want=00", n, bus.valid);
            end
        end
    endtask

    task automatic test_constant();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        apply_reset();
        for (int n = 0; n <= 4 * ROW; n++) begin
            if (n < 4 * ROW) img[n / ROW][n % ROW] = 8'h64;
            drive(8'h64);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = 8'h64;
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL constant n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
    endtask

    // Expected impulse response straight from the kernel table for 0xFF at (5,5).
    function automatic logic [7:0] impulse_exp(input int r, input int c);
        int dy, dx;
        dy = iabs(5 - (r - 1));
        dx = iabs(5 - (c - 1));
        if (dy > 1 || dx > 1) return 8'h00;
        case ((2 - dy) * (2 - dx))
            4:       return 8'h3F;
            2:       return 8'h1F;
            default: return 8'h0F;
        endcase
    endfunction

    task automatic test_impulse();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        logic [7:0] px;
        apply_reset();
        for (int n = 0; n <= 8 * ROW; n++) begin
            px = (n == 5 * ROW + 5) ? 8'hFF : 8'h00;
            drive(px);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = impulse_exp(pr, pc);
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL impulse n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
    endtask

    task automatic test_saturation();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        apply_reset();
        for (int n = 0; n <= 3 * ROW + 3; n++) begin
            drive(8'hFF);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = 8'hFF;
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL saturation n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
    endtask

    task automatic test_random();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        logic [7:0] px;
        apply_reset();
        for (int n = 0; n <= 4 * ROW; n++) begin
            px = 8'($urandom);
            if (n < 4 * ROW) img[n / ROW][n % ROW] = px;
            drive(px);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = model_px(pr, pc);
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL random n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
    endtask

    task automatic test_midstream_reset();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        logic [7:0] px;
        apply_reset();
        for (int n = 0; n < 3 * ROW + 100; n++) begin
            px = 8'($urandom);
            img[n / ROW][n % ROW] = px;
            drive(px);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = model_px(pr, pc);
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL pre_reset n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
        rst = 1'b0;
        bus.inputPixel = 8'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (bus.valid !== 2'b00 || bus.outputPixel !== 8'h00) begin
            failures++;
            $display("FAIL midreset valid=%b want=00 pixel=%h want=00",
                     bus.valid, bus.outputPixel);
        end
        for (int n = 0; n <= 2 * ROW + 4; n++) begin
            px = 8'($urandom);
            img[n / ROW][n % ROW] = px;
            drive(px);
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / ROW;
                pc = (n - 1) % ROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) ep = model_px(pr, pc);
            end
            checks++;
            if (bus.valid !== ev || bus.outputPixel !== ep) begin
                failures++;
                $display("FAIL post_reset n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus.valid, ev, bus.outputPixel, ep);
            end
        end
    endtask

    task automatic test_small();
        int pr, pc;
        logic [1:0] ev;
        logic [7:0] ep;
        rst_s = 1'b0;
        bus_s.inputPixel = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst_s = 1'b1;
        for (int n = 0; n <= SROW * SROW; n++) begin
            bus_s.inputPixel = 8'(16 * (n / SROW) + (n % SROW));
            @(posedge clk);
            #1;
            ev = 2'b00;
            ep = 8'h00;
            if (n > 0) begin
                pr = (n - 1) / SROW;
                pc = (n - 1) % SROW;
                ev = model_code(pr, pc);
                if (ev == 2'b01) begin
                    case ({pr[1:0], pc[1:0]})
                        4'b1010: ep = 8'h11;
                        4'b1011: ep = 8'h12;
                        4'b1110: ep = 8'h21;
                        default: ep = 8'h22;
                    endcase
                end
            end
            checks++;
            if (bus_s.valid !== ev || bus_s.outputPixel !== ep) begin
                failures++;
                $display("FAIL small n=%0d valid=%b want=%b pixel=%h want=%h",
                         n - 1, bus_s.valid, ev, bus_s.outputPixel, ep);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        rst_s    = 1'b0;
        bus.inputPixel   = 8'h00;
        bus_s.inputPixel = 8'h00;
        test_reset();
        test_constant();
        test_impulse();
        test_saturation();
        test_random();
        test_midstream_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
